barrel_fetch_unit: RTL and testbench
====================================

# barrel_fetch_unit

Instruction-fetch stage of the 16-thread barrel RISC-V core, directly upstream of decode and the BRAM register file. It keeps one program counter per hardware thread and selects one thread per cycle in fixed round-robin order. It issues that thread's word address to the 1-cycle-latency instruction BRAM and presents {valid, thread id, PC, instruction} to decode one cycle later. Control-flow redirects from execute are written back into the per-thread PC array, with a same-cycle bypass.

## Interface
- NUM_THREADS, 16, hardware threads; power of two.
- TID_WIDTH, clog2(NUM_THREADS) = 4, thread-id width.
- PC_WIDTH, 12, byte-address PC width.
- ADDR_WIDTH, 10, instruction BRAM word-address width; equals PC_WIDTH-2.
- IWIDTH, 32, instruction width.
- STARTUP_ADDR, 12'h000, reset PC of every thread.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- stall_i  in  1  freeze fetch: no issue, outputs held.
- thread_en_i  in  NUM_THREADS  per-thread enable; a disabled thread's slot issues a bubble.
- redirect_valid_i  in  1  execute-stage PC redirect strobe.
- redirect_tid_i  in  TID_WIDTH  thread being redirected.
- redirect_pc_i  in  PC_WIDTH  new byte PC.
- imem_en_o  out  1  BRAM read enable.
- imem_addr_o  out  ADDR_WIDTH  BRAM word address.
- imem_rdata_i  in  IWIDTH  BRAM read data, valid 1 cycle after enable.
- fetch_valid_o  out  1  slot carries a real instruction.
- fetch_tid_o  out  TID_WIDTH  thread id of slot.
- fetch_pc_o  out  PC_WIDTH  byte PC of slot.
- fetch_instr_o  out  IWIDTH  instruction; combinational pass of imem_rdata_i.

## Operation
**State**
- pc_q[NUM_THREADS] in flops.
- tid_q slot counter.
- F1 registers: valid, tid, pc.

**F0 (issue), cycle n, when stall_i=0**
- Selected PC: if redirect_valid_i and redirect_tid_i==tid_q, sel = {redirect_pc_i[11:2],2'b00} (bypass). Otherwise sel = pc_q[tid_q].
- imem_en_o = 1. imem_addr_o = sel[11:2].
- pc_q[tid_q] <= sel+4, modulo 2^PC_WIDTH; 12'hFFC wraps to 12'h000.
- F1 valid <= thread_en_i[tid_q]. F1 tid <= tid_q. F1 pc <= sel.
- tid_q <= tid_q+1, wrapping NUM_THREADS-1 to 0.
- A disabled thread still advances its PC, so a thread re-enabled mid-stream resumes at an undefined-but-aligned address. Software must redirect the thread before enabling it.

**Redirect, other thread**
- If redirect_tid_i != tid_q: pc_q[redirect_tid_i] <= {redirect_pc_i[11:2],2'b00}.
- This applies whether or not the target thread is enabled and whether or not stall_i is asserted.
- Redirect bits [1:0] are always forced to 0.

**Stall (stall_i=1)**
- imem_en_o=0, so the BRAM output holds.
- tid_q, the F1 registers and the non-redirected pc_q entries hold.
- All fetch_* outputs are stable for the duration of the stall.
- A redirect to tid_q during a stall updates pc_q[tid_q] to the aligned redirect PC (no +4). That value is used when the stall releases.

**Reset (reset_n=0, any time)**
- Asynchronously: all pc_q=STARTUP_ADDR, tid_q=0, fetch_valid_o=0, fetch_tid_o=0, fetch_pc_o=0.
- imem_en_o=0 while reset is asserted; imem_addr_o is don't-care.
- An in-flight fetch is discarded.

## Timing
- Issue-to-decode latency is 1 cycle. F0 at edge n gives fetch_valid_o/fetch_tid_o/fetch_pc_o at n+1, aligned with imem_rdata_i.
- Throughput is 1 slot per cycle. Each thread issues once every NUM_THREADS un-stalled cycles.
- First issue: thread 0 at STARTUP_ADDR in the first cycle after reset_n deasserts (if stall_i=0).
- A redirect accepted at edge n takes effect at that thread's next issue slot at or after cycle n, including the same cycle via the bypass.
- No combinational path from redirect_* or stall_i to any fetch_* output.
- The only combinational paths to outputs are:
  - redirect/tid to imem_addr_o;
  - stall_i to imem_en_o;
  - imem_rdata_i to fetch_instr_o.

## Test plan
- **Reset release**, all threads enabled, no redirects:
  - Cycles 1..16 issue tid 0..15 at PC 0x000 each.
  - Cycles 17..32 issue tid 0..15 at PC 0x004.
  - fetch_* outputs lag issue by 1 cycle; fetch_instr_o matches a preloaded BRAM.
- **Same-cycle bypass**: redirect tid 5 to 0x123 in the cycle tid_q=5.
  - imem_addr_o=0x048 that cycle.
  - fetch_pc_o=0x120 next cycle.
  - Thread 5's following slot uses PC 0x124.
- **Stall**: stall_i high 3 cycles mid-stream, with a redirect of tid 9 to 0x200 during the stall.
  - imem_en_o=0 and all fetch_* outputs constant during the stall.
  - Round-robin resumes at the frozen tid.
  - Thread 9's next fetch is at 0x200.
- **Thread enable**: thread_en_i=16'h0001.
  - Only tid 0 slots have fetch_valid_o=1, at PCs 0x000, 0x004, …
  - Other slots are bubbles.
- **PC wrap**: redirect tid 3 to 0xFFC.
  - Thread 3 fetches 0xFFC, then 0x000.
- **Reset mid-operation**: assert reset_n low while tid_q=7.
  - fetch_valid_o drops to 0 immediately, before the next clock edge.
  - After release, thread 0 issues at STARTUP_ADDR.

Source files
------------

// File: rtl/barrel_fetch_unit.sv
// barrel_fetch_unit
//
// Instruction-fetch stage of the 16-thread barrel RISC-V core. It holds one
// program counter per hardware thread and picks one thread per cycle in
// fixed round-robin order (F0). It sends that thread's word address to a
// 1-cycle-latency instruction BRAM. One cycle later (F1) it presents the
// slot to decode, aligned with the BRAM read data.
//
// Ports
//   clk              : single clock, rising edge
//   reset_n          : asynchronous, active-low reset
//   stall_i          : freeze fetch (no issue, outputs held)
//   thread_en_i      : per-thread enable; a disabled slot becomes a bubble
//   redirect_valid_i : execute-stage PC redirect strobe
//   redirect_tid_i   : thread being redirected
//   redirect_pc_i    : new byte PC (bits [1:0] ignored)
//   imem_en_o        : BRAM read enable
//   imem_addr_o      : BRAM word address
//   imem_rdata_i     : BRAM read data, valid one cycle after imem_en_o
//   fetch_valid_o    : slot carries a real instruction
//   fetch_tid_o      : thread id of the slot
//   fetch_pc_o       : byte PC of the slot
//   fetch_instr_o    : instruction (combinational pass of imem_rdata_i)
//
// Output protocol: decode has no back-pressure, so there is no ready signal.
// A slot is presented on every cycle that follows an un-stalled clock edge.
// fetch_valid_o=1 means the slot carries a real instruction for fetch_tid_o
// at fetch_pc_o. fetch_valid_o=0 marks a bubble. During a stall all fetch_*
// outputs hold their last value.

module barrel_fetch_unit #(
  parameter int                    NUM_THREADS  = 16,
  parameter int                    TID_WIDTH    = $clog2(NUM_THREADS),
  parameter int                    PC_WIDTH     = 12,
  parameter int                    ADDR_WIDTH   = PC_WIDTH - 2,
  parameter int                    IWIDTH       = 32,
  parameter logic [PC_WIDTH-1:0]   STARTUP_ADDR = '0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   stall_i,
  input  logic [NUM_THREADS-1:0] thread_en_i,
  input  logic                   redirect_valid_i,
  input  logic [TID_WIDTH-1:0]   redirect_tid_i,
  input  logic [PC_WIDTH-1:0]    redirect_pc_i,
  output logic                   imem_en_o,
  output logic [ADDR_WIDTH-1:0]  imem_addr_o,
  input  logic [IWIDTH-1:0]      imem_rdata_i,
  output logic                   fetch_valid_o,
  output logic [TID_WIDTH-1:0]   fetch_tid_o,
  output logic [PC_WIDTH-1:0]    fetch_pc_o,
  output logic [IWIDTH-1:0]      fetch_instr_o
);

  logic [PC_WIDTH-1:0]  pc_q [NUM_THREADS];
  logic [TID_WIDTH-1:0] tid_q;

  logic                 f1_valid_q;
  logic [TID_WIDTH-1:0] f1_tid_q;
  logic [PC_WIDTH-1:0]  f1_pc_q;

  logic [PC_WIDTH-1:0]  redirect_pc_aligned;
  logic [PC_WIDTH-1:0]  sel_pc;
  logic [PC_WIDTH-1:0]  sel_pc_next;
  logic                 bypass;
  logic                 issue;

  // Instructions are word aligned, so the low two redirect bits are dropped.
  assign redirect_pc_aligned = redirect_pc_i & ~PC_WIDTH'(3);

  // A redirect aimed at the thread issuing this cycle wins over the stored PC.
  // Without this bypass, that thread would fetch one stale instruction.
  assign bypass      = redirect_valid_i && (redirect_tid_i == tid_q);
  assign sel_pc      = bypass ? redirect_pc_aligned : pc_q[tid_q];
  assign sel_pc_next = sel_pc + PC_WIDTH'(4);

  // Keeping the enable low during reset and stall holds the BRAM output.
  // That hold is what keeps fetch_instr_o stable through a stall.
  assign issue       = reset_n && !stall_i;
  assign imem_en_o   = issue;
  assign imem_addr_o = sel_pc[PC_WIDTH-1:2];

  assign fetch_valid_o = f1_valid_q;
  assign fetch_tid_o   = f1_tid_q;
  assign fetch_pc_o    = f1_pc_q;
  assign fetch_instr_o = imem_rdata_i;

  // Per-thread PC array.
  // The issuing slot takes priority over a redirect, because the bypass has
  // already folded that redirect into sel_pc. During a stall the issuing slot
  // does not advance, so a redirect to tid_q stores the aligned PC without +4.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        pc_q[i] <= STARTUP_ADDR;
      end
    end else begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        if (!stall_i && (tid_q == TID_WIDTH'(i))) begin
          pc_q[i] <= sel_pc_next;
        end else if (redirect_valid_i && (redirect_tid_i == TID_WIDTH'(i))) begin
          pc_q[i] <= redirect_pc_aligned;
        end
      end
    end
  end

  // Round-robin slot counter and F1 pipeline registers.
  // NUM_THREADS is a power of two, so the counter wraps on its own.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tid_q      <= '0;
      f1_valid_q <= 1'b0;
      f1_tid_q   <= '0;
      f1_pc_q    <= '0;
    end else if (!stall_i) begin
      tid_q      <= tid_q + TID_WIDTH'(1);
      f1_valid_q <= thread_en_i[tid_q];
      f1_tid_q   <= tid_q;
      f1_pc_q    <= sel_pc;
    end
  end

endmodule

// File: tb/tb_barrel_fetch_unit.sv
// Testbench for barrel_fetch_unit.
// Directed stimulus. The driver issues one slot per cycle and pushes that
// slot's expected response into exp_q. A monitor pops exp_q one cycle later
// and compares the entry against the fetch_* outputs.

module tb_barrel_fetch_unit;

  localparam int NT = 16;
  localparam int TW = 4;
  localparam int PW = 12;
  localparam int AW = 10;
  localparam int IW = 32;
  localparam int EW = 1 + TW + PW + IW;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset_n;
  logic          stall_i;
  logic [NT-1:0] thread_en_i;
  logic          redirect_valid_i;
  logic [TW-1:0] redirect_tid_i;
  logic [PW-1:0] redirect_pc_i;
  logic          imem_en_o;
  logic [AW-1:0] imem_addr_o;
  logic [IW-1:0] imem_rdata_i;
  logic          fetch_valid_o;
  logic [TW-1:0] fetch_tid_o;
  logic [PW-1:0] fetch_pc_o;
  logic [IW-1:0] fetch_instr_o;

  always #5 clk = ~clk;

  barrel_fetch_unit dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .stall_i          (stall_i),
    .thread_en_i      (thread_en_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_tid_i   (redirect_tid_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_en_o        (imem_en_o),
    .imem_addr_o      (imem_addr_o),
    .imem_rdata_i     (imem_rdata_i),
    .fetch_valid_o    (fetch_valid_o),
    .fetch_tid_o      (fetch_tid_o),
    .fetch_pc_o       (fetch_pc_o),
    .fetch_instr_o    (fetch_instr_o)
  );

  // ---------------- instruction BRAM model ----------------
  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    return {16'hC0DE, 6'd0, a};
  endfunction

  logic [IW-1:0] imem [1 << AW];

  initial begin
    for (int i = 0; i < (1 << AW); i++) imem[i] = mem_word(AW'(i));
  end

  always @(posedge clk) begin
    if (imem_en_o) imem_rdata_i <= imem[imem_addr_o];
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    logic          iss;
    logic [EW-1:0] e;
    forever begin
      @(posedge clk);
      iss = reset_n && !stall_i;
      @(negedge clk);
      if (iss) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL scoreboard_underflow: got slot tid %0h expected none", fetch_tid_o);
        end else begin
          e = exp_q.pop_front();
          check("fetch_valid", fetch_valid_o, e[EW-1]);
          check("fetch_tid",   fetch_tid_o,   e[EW-2 -: TW]);
          check("fetch_pc",    fetch_pc_o,    e[PW+IW-1 -: PW]);
          check("fetch_instr", fetch_instr_o, e[IW-1:0]);
        end
      end
    end
  end

  // ---------------- driver ----------------
  logic [PW-1:0] exp_pc_tbl [NT];
  int            cur_tid;

  // Called just after a falling edge with inputs set. It checks the F0
  // address, queues the expected F1 slot, and advances to the next falling edge.
  task automatic slot();
    logic [PW-1:0] p;
    p = exp_pc_tbl[cur_tid];
    #1;
    check("imem_en",   imem_en_o,   1);
    check("imem_addr", imem_addr_o, p[PW-1:2]);
    exp_q.push_back({thread_en_i[cur_tid], TW'(cur_tid), p, mem_word(p[PW-1:2])});
    exp_pc_tbl[cur_tid] = p + 12'd4;
    cur_tid = (cur_tid + 1) % NT;
    @(negedge clk);
  endtask

  task automatic run_slots(input int n);
    for (int i = 0; i < n; i++) slot();
  endtask

  task automatic reset_tbl();
    for (int i = 0; i < NT; i++) exp_pc_tbl[i] = 12'h000;
    cur_tid = 0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n          = 1'b0;
    stall_i          = 1'b0;
    thread_en_i      = '1;
    redirect_valid_i = 1'b0;
    redirect_tid_i   = '0;
    redirect_pc_i    = '0;
    imem_rdata_i     = '0;
    reset_tbl();

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid",   fetch_valid_o, 0);
    check("rst_tid",     fetch_tid_o,   0);
    check("rst_pc",      fetch_pc_o,    0);
    check("rst_imem_en", imem_en_o,     0);
    reset_n = 1'b1;

    // Reset release: two full rounds at 0x000 then 0x004
    run_slots(32);

    // Same-cycle bypass: tid 5 to 0x123 -> fetched at 0x120, then 0x124
    run_slots(5);
    redirect_valid_i = 1'b1;
    redirect_tid_i   = 4'd5;
    redirect_pc_i    = 12'h123;
    exp_pc_tbl[5]    = 12'h120;
    slot();
    redirect_valid_i = 1'b0;
    run_slots(10 + 16);

    // Stall for 3 cycles with a redirect of tid 9 during the stall
    run_slots(4);
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        redirect_valid_i = 1'b1;
        redirect_tid_i   = 4'd9;
        redirect_pc_i    = 12'h202;
      end else begin
        redirect_valid_i = 1'b0;
      end
      #1;
      check("stall_imem_en", imem_en_o,     0);
      check("stall_valid",   fetch_valid_o, 1);
      check("stall_tid",     fetch_tid_o,   3);
      check("stall_pc",      fetch_pc_o,    12'h010);
      check("stall_instr",   fetch_instr_o, mem_word(10'h004));
      @(negedge clk);
    end
    stall_i          = 1'b0;
    redirect_valid_i = 1'b0;
    exp_pc_tbl[9]    = 12'h200;
    run_slots(12);

    // Thread enable: only tid 0 valid, others are bubbles
    thread_en_i = 16'h0001;
    run_slots(32);
    thread_en_i = '1;

    // PC wrap: tid 3 to 0xFFC (redirected from another slot), then 0x000
    redirect_valid_i = 1'b1;
    redirect_tid_i   = 4'd3;
    redirect_pc_i    = 12'hFFE;
    exp_pc_tbl[3]    = 12'hFFC;
    slot();
    redirect_valid_i = 1'b0;
    run_slots(15 + 16);

    // Reset mid-operation with tid_q = 7
    run_slots(7);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_valid",   fetch_valid_o, 0);
    check("midrst_tid",     fetch_tid_o,   0);
    check("midrst_pc",      fetch_pc_o,    0);
    check("midrst_imem_en", imem_en_o,     0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    reset_tbl();
    run_slots(4);

    stall_i = 1'b1;
    @(negedge clk);
    check("queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
